// File: rtl/bit_scan_serializer_pkg.sv
// Shared types and constants for the bit scan serializer.
//   SEL_W / DATA_W : select index width and parallel word width (DATA_W == 2**SEL_W)
//   scan_desc_t    : scan descriptor {start_sel, stride, len_m1}
//   state_e        : FSM states {IDLE, SCAN}
package bit_scan_serializer_pkg;

  localparam int SEL_W  = 8;
  localparam int DATA_W = 1 << SEL_W;

  typedef struct packed {
    logic [SEL_W-1:0] start_sel;
    logic [SEL_W-1:0] stride;
    logic [SEL_W-1:0] len_m1;
  } scan_desc_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/bit_scan_serializer_if.sv
// Word-in / bit-out handshake bundle for the bit scan serializer.
//   in_*      : parallel word + scan descriptor, valid/ready
//   out_*     : serial bit stream, valid/ready, with last marker
//   sel, busy : observability of the select counter and scan state
// master = upstream/downstream environment side, slave = serializer side.
interface bit_scan_serializer_if
  import bit_scan_serializer_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int SEL_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  start_sel;
  logic [SEL_W-1:0]  stride;
  logic [SEL_W-1:0]  len_m1;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic              out_last;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  modport master (
    output in_valid, in_data, start_sel, stride, len_m1, out_ready,
    input  in_ready, out_valid, out_bit, out_last, sel, busy
  );

  modport slave (
    input  in_valid, in_data, start_sel, stride, len_m1, out_ready,
    output in_ready, out_valid, out_bit, out_last, sel, busy
  );

endinterface

// File: rtl/bit_scan_serializer_mux.sv
// 256-to-1 bit-select mux.
//   in  : parallel word
//   sel : bit index
//   out : in[sel]
module mux_256to1 #(
  parameter int DATA_W = 256,
  parameter int SEL_W  = 8
) (
  input  logic [DATA_W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);

  assign out = in[sel];

endmodule

// File: rtl/bit_scan_serializer.sv
// Bit scan serializer: captures a word plus scan descriptor, then walks the
// select index (start, +stride mod 2**SEL_W) through it, emitting one bit per
// accepted beat on a valid/ready stream.
//   clk, areset_n : clock, asynchronous active-low reset
//   bus (slave)   : in_* word/descriptor handshake, out_* serial stream,
//                   sel/busy observability
// All out_* are derived from registered state only; in_ready additionally
// looks at out_ready so a new word can load on the edge that retires the
// last bit of the previous scan (no bubble between scans).
module bit_scan_serializer
  import bit_scan_serializer_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int SEL_W  = 8
) (
  input  logic                 clk,
  input  logic                 areset_n,
  bit_scan_serializer_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  stride_q, stride_d;
  logic [SEL_W-1:0]  rem_q, rem_d;

  scan_desc_t in_desc;
  logic       mux_bit;
  logic       beat;
  logic       last;
  logic       load;

  assign in_desc = '{start_sel: bus.start_sel, stride: bus.stride, len_m1: bus.len_m1};

  assign last = (rem_q == '0);
  assign beat = bus.out_valid & bus.out_ready;
  assign load = bus.in_valid & bus.in_ready;

  mux_256to1 #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_mux (
    .in  (data_q),
    .sel (sel_q),
    .out (mux_bit)
  );

  // State register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      sel_q    <= '0;
      stride_q <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
    end
  end

  // Next state / datapath
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    if (beat) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        sel_d = sel_q + stride_q;  // wraps naturally at SEL_W bits
        rem_d = rem_q - 1'b1;
      end
    end
    // A load overrides the return to IDLE when it coincides with the last beat.
    if (load) begin
      state_d  = SCAN;
      data_d   = bus.in_data;
      sel_d    = in_desc.start_sel;
      stride_d = in_desc.stride;
      rem_d    = in_desc.len_m1;
    end
  end

  // Outputs
  always_comb begin
    bus.out_valid = (state_q == SCAN);
    bus.busy      = (state_q == SCAN);
    bus.out_last  = (state_q == SCAN) & last;
    bus.out_bit   = mux_bit;
    bus.sel       = sel_q;
    bus.in_ready  = (state_q == IDLE) | ((state_q == SCAN) & bus.out_ready & last);
  end

endmodule

// File: tb/tb_bit_scan_serializer.sv
module tb_bit_scan_serializer;
  import bit_scan_serializer_pkg::*;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  bit_scan_serializer_if bus ();

  bit_scan_serializer dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference: index of beat k is (start + k*stride) mod 256.
  function automatic logic [7:0] ref_idx(input int s, input int st, input int k);
    return 8'((s + k * st) % 256);
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Presents one word at a negedge while the DUT is ready; returns at the next
  // negedge with inputs scrambled so later sampling would be caught.
  task automatic load(input logic [255:0] w, input logic [7:0] s, input logic [7:0] st,
                      input logic [7:0] l);
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    bus.start_sel = s;
    bus.stride    = st;
    bus.len_m1    = l;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = rand_word();
    bus.start_sel = 8'($urandom);
    bus.stride    = 8'($urandom);
    bus.len_m1    = 8'($urandom);
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_last !== 1'b0 || bus.sel !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: valid=%b busy=%b last=%b sel=%h, want 0 0 0 00",
               bus.out_valid, bus.busy, bus.out_last, bus.sel);
    end
    @(negedge clk);
    areset_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sel !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b valid=%b sel=%h, want 1 0 00",
               bus.in_ready, bus.out_valid, bus.sel);
    end
    @(negedge clk);
  endtask

  task automatic test_walking();
    logic [255:0] w;
    for (int p = 0; p < 3; p++) begin
      w = 256'h1;
      w = w << $urandom_range(255);
      if (p == 1) w = ~w;
      if (p == 2) w = rand_word();
      bus.out_ready = 1'b1;
      load(w, 8'h00, 8'h01, 8'hFF);
      for (int k = 0; k < 256; k++) begin
        #1;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_bit !== w[k] || bus.sel !== 8'(k) ||
            bus.out_last !== (k == 255) || bus.in_ready !== (k == 255)) begin
          errors++;
          $display("FAIL walking p%0d beat %0d: valid=%b bit=%b sel=%h last=%b in_ready=%b, want 1 %b %h %b %b",
                   p, k, bus.out_valid, bus.out_bit, bus.sel, bus.out_last, bus.in_ready,
                   w[k], 8'(k), k == 255, k == 255);
        end
        @(negedge clk);
      end
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL walking_idle: valid=%b in_ready=%b busy=%b, want 0 1 0",
                 bus.out_valid, bus.in_ready, bus.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]   seq [4] = '{8'hFE, 8'h01, 8'h04, 8'h07};
    logic [255:0] w = rand_word();
    bus.out_ready = 1'b1;
    load(w, 8'hFE, 8'h03, 8'h03);
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.sel !== seq[k] || bus.out_bit !== w[seq[k]] ||
          bus.out_last !== (k == 3)) begin
        errors++;
        $display("FAIL wrap beat %0d: valid=%b sel=%h bit=%b last=%b, want 1 %h %b %b",
                 k, bus.out_valid, bus.sel, bus.out_bit, bus.out_last, seq[k], w[seq[k]], k == 3);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_idle: valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [255:0] w;
    logic [7:0]   s, st, l, idx;
    int           beat, cyc;
    for (int n = 0; n < 8; n++) begin
      w  = rand_word();
      s  = 8'($urandom);
      st = (n == 1) ? 8'h00 : 8'($urandom);
      l  = (n == 0) ? 8'd7 : 8'($urandom_range(20));
      load(w, s, st, l);
      beat = 0;
      cyc  = 0;
      while (beat <= int'(l) && cyc < 400) begin
        bus.out_ready = 1'($urandom);
        #1;
        idx = ref_idx(s, st, beat);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.sel !== idx || bus.out_bit !== w[idx] ||
            bus.out_last !== (beat == int'(l)) ||
            bus.in_ready !== (bus.out_ready && beat == int'(l))) begin
          errors++;
          $display("FAIL backpressure scan %0d beat %0d: valid=%b sel=%h bit=%b last=%b in_ready=%b, want 1 %h %b %b %b",
                   n, beat, bus.out_valid, bus.sel, bus.out_bit, bus.out_last, bus.in_ready,
                   idx, w[idx], beat == int'(l), bus.out_ready && beat == int'(l));
        end
        @(posedge clk);
        if (bus.out_ready) beat++;
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 400) begin
        errors++;
        $display("FAIL backpressure_timeout scan %0d: beats=%0d, want %0d", n, beat, int'(l) + 1);
      end
      bus.out_ready = 1'b1;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_idle scan %0d: valid=%b in_ready=%b, want 0 1",
                 n, bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wa = rand_word();
    logic [255:0] wb = rand_word();
    logic [7:0]   sa = 8'($urandom), sta = 8'($urandom);
    logic [7:0]   sb = 8'($urandom), stb = 8'($urandom);
    logic [7:0]   idx;
    bus.out_ready = 1'b1;
    load(wa, sa, sta, 8'd3);
    for (int k = 0; k < 4; k++) begin
      if (k >= 1) begin
        bus.in_valid  = 1'b1;
        bus.in_data   = wb;
        bus.start_sel = sb;
        bus.stride    = stb;
        bus.len_m1    = 8'd5;
      end
      #1;
      idx = ref_idx(sa, sta, k);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.sel !== idx || bus.out_bit !== wa[idx] ||
          bus.out_last !== (k == 3) || bus.in_ready !== (k == 3)) begin
        errors++;
        $display("FAIL b2b_first beat %0d: valid=%b sel=%h bit=%b last=%b in_ready=%b, want 1 %h %b %b %b",
                 k, bus.out_valid, bus.sel, bus.out_bit, bus.out_last, bus.in_ready,
                 idx, wa[idx], k == 3, k == 3);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = rand_word();
    for (int k = 0; k < 6; k++) begin
      #1;
      idx = ref_idx(sb, stb, k);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.sel !== idx || bus.out_bit !== wb[idx] ||
          bus.out_last !== (k == 5)) begin
        errors++;
        $display("FAIL b2b_second beat %0d: valid=%b sel=%h bit=%b last=%b, want 1 %h %b %b",
                 k, bus.out_valid, bus.sel, bus.out_bit, bus.out_last, idx, wb[idx], k == 5);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_stride0();
    logic [255:0] w = rand_word();
    bus.out_ready = 1'b1;
    load(w, 8'h80, 8'h00, 8'h00);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_bit !== w[128] || bus.out_last !== 1'b1 ||
        bus.sel !== 8'h80) begin
      errors++;
      $display("FAIL single: valid=%b bit=%b last=%b sel=%h, want 1 %b 1 80",
               bus.out_valid, bus.out_bit, bus.out_last, bus.sel, w[128]);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: valid=%b in_ready=%b busy=%b, want 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [255:0] w  = rand_word();
    logic [255:0] w2 = rand_word();
    logic [7:0]   s  = 8'($urandom), st = 8'($urandom);
    logic [7:0]   s2 = 8'($urandom), st2 = 8'($urandom);
    logic [7:0]   idx;
    bus.out_ready = 1'b1;
    load(w, s, st, 8'd15);
    repeat (3) @(negedge clk);
    #2;
    areset_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 8'h00 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b sel=%h last=%b, want 0 0 00 0",
               bus.out_valid, bus.busy, bus.sel, bus.out_last);
    end
    @(negedge clk);
    areset_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: in_ready=%b valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    load(w2, s2, st2, 8'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      idx = ref_idx(s2, st2, k);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.sel !== idx || bus.out_bit !== w2[idx] ||
          bus.out_last !== (k == 2)) begin
        errors++;
        $display("FAIL reset_mid_rescan beat %0d: valid=%b sel=%h bit=%b last=%b, want 1 %h %b %b",
                 k, bus.out_valid, bus.sel, bus.out_bit, bus.out_last, idx, w2[idx], k == 2);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle: valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.start_sel = '0;
    bus.stride    = '0;
    bus.len_m1    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_walking();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_single_stride0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bit_scan_serializer.md
Name: bit_scan_serializer

Overview:
- Sequencing stage that feeds the 256-to-1 bit-select mux.
- Accepts a 256-bit word plus a scan descriptor (start index, stride, length) over a valid/ready handshake.
- Walks the 8-bit select index through the word and emits one selected bit per accepted beat on a valid/ready serial stream.
- Sits between the word-producing block upstream and the bit-serial consumer downstream. It owns the select counter; the mux is instantiated inside it.

Parameters:
- DATA_W, 256, width of the parallel word; must equal 2**SEL_W.
- SEL_W, 8, width of the select index, stride and length fields.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- areset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word plus descriptor valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  word to scan.
- start_sel  input  SEL_W  index of the first bit emitted.
- stride  input  SEL_W  added to the index after each emitted bit, modulo 2**SEL_W.
- len_m1  input  SEL_W  number of bits to emit, minus 1 (0 means 1 bit, 255 means 256 bits).
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts out_bit.
- out_bit  output  1  currently selected bit, in_data_q[sel_q].
- out_last  output  1  high with the final bit of a scan.
- sel  output  SEL_W  current select index; debug/observability.
- busy  output  1  a scan is in progress (state SCAN).

Behaviour:
- Reset (areset_n low, asynchronous):
  - state goes to IDLE.
  - data_q, sel_q and rem_q all go to 0.
  - out_valid, out_last and busy read 0.
  - in_ready reads 1 as soon as reset is released.
- The FSM has two states, IDLE and SCAN.
- In IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&in_ready: data_q<=in_data, sel_q<=start_sel, stride_q<=stride, rem_q<=len_m1, then go to SCAN.
- In SCAN:
  - out_valid=1.
  - out_bit=data_q[sel_q] and sel=sel_q.
  - out_last=(rem_q==0).
- A beat completes on out_valid&out_ready.
  - If not last: sel_q<=sel_q+stride_q, truncated to SEL_W so it wraps 255+1 to 0; rem_q<=rem_q-1.
  - If last: go to IDLE, unless a new word loads in the same cycle (see next item).
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
  - A new word can therefore load on the same edge as the last beat is accepted.
  - In that case the FSM stays in SCAN with the new descriptor and there is no bubble.
- Latency: the first bit of a word is valid the cycle after it is accepted. At full throughput a scan of N bits occupies exactly N cycles.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_bit, out_last, sel, data_q and rem_q hold.
  - In that condition in_ready=0.
- stride=0 is legal: the same bit is emitted len_m1+1 times.
- in_data and the descriptor are sampled only on acceptance. Changes to these inputs while busy are ignored.
- There is no combinational path from in_* to out_*. out_* depend only on registered state.
- Reset asserted mid-scan aborts the scan immediately: out_valid drops asynchronously, and the partial scan is not resumed.

Decomposition:
- Shared package defines:
  - SEL_W and DATA_W constants.
  - A packed scan_desc_t struct {start_sel, stride, len_m1}.
  - The state enum {IDLE, SCAN}.
- One natural sub-module is mux_256to1 (in[DATA_W], sel[SEL_W], out), driven by data_q and sel_q and producing out_bit.

Test Plan:
- Walking scan: in_data=256'h1 shifted through patterns, start_sel=0, stride=1, len_m1=255, out_ready=1.
  - Expect 256 beats, bit i = in_data[i].
  - out_last only on beat 255.
  - in_ready low for beats 0..254.
- Wrap-around: start_sel=8'hFE, stride=3, len_m1=3.
  - sel sequence must be FE, 01, 04, 07.
  - out_bit must match in_data at each index.
  - out_last on the 4th beat.
- Backpressure: out_ready toggled randomly during a scan with len_m1=7.
  - out_bit and sel hold whenever out_ready=0.
  - Exactly 8 beats accepted, in order.
- Back-to-back: second word presented with in_valid=1 during the last beat of the first.
  - Second word accepted on that edge.
  - Its first bit appears the next cycle with no idle cycle.
- Single bit with stride 0: len_m1=0, start_sel=8'h80, stride=0.
  - One beat equal to in_data[128], with out_last=1.
  - Then IDLE, in_ready=1.
- Reset mid-scan: areset_n low asynchronously after 3 of 16 beats.
  - out_valid=0, busy=0, sel=0 immediately.
  - After release in_ready=1 and the next word scans from its own start_sel.
